spi_write_decoder: RTL
======================

// Module: spi_write_decoder
// PURPOSE
//  Upstream stage of the text-mode memory controller. Oversamples host SPI (SCK/MOSI/SS) in the
//  system clock domain, assembles MSB-first bytes, parses write frames and issues single-cycle
//  write strobes with auto-incrementing addresses into the character RAM or the font RAM.
//  Also exposes frame status for the onboard LEDs.
// PARAMETERS
//  SYNC_STAGES  2   flop stages on each SPI input before edge detection (min 2)
//  CHAR_AW      13  character RAM address width
//  FONT_AW      12  font RAM address width
// PORTS
//  clk          in   1   50 MHz system clock
//  rst_n        in   1   synchronous reset, active low
//  spi_sck      in   1   host SPI clock, async, mode 0, f_sck <= clk/8
//  spi_mosi     in   1   host data, sampled on SCK rising edge
//  spi_ss_n     in   1   frame select, active low, async
//  wr_en        out  1   one-cycle write strobe
//  wr_font      out  1   target of wr_en: 1 = font RAM, 0 = character RAM
//  wr_addr      out  16  write address, zero-extended from CHAR_AW/FONT_AW
//  wr_data      out  8   write data
//  busy         out  1   high while a frame is open (synced SS low)
//  cmd_err      out  1   one-cycle pulse: unknown command byte
//  frame_err    out  1   one-cycle pulse: SS deasserted with a partial byte
//  status       out  8   {err_sticky, wr_font, state[2:0], byte_cnt_sat[2:0]} for LEDs
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): all outputs 0; FSM -> IDLE; shift reg, bit count, addr cleared.
//  - Inputs pass SYNC_STAGES flops; SCK rise = synced sck 0->1. SS high forces bit count to 0.
//  - Byte done on 8th SCK rise; byte_valid internal pulse the following clk.
//  - FSM (advances on byte_valid only, except SS):
//      IDLE    : synced SS low -> CMD
//      CMD     : 0x01 -> ADDR_H (wr_font<=0); 0x02 -> ADDR_H (wr_font<=1);
//                other -> DISCARD + cmd_err pulse
//      ADDR_H  : addr[15:8] <= byte -> ADDR_L
//      ADDR_L  : addr[7:0] <= byte, masked to target width -> DATA
//      DATA    : each byte -> wr_en=1 one clk, wr_data=byte, wr_addr=addr; addr+1 next clk
//      DISCARD : ignore bytes until SS high
//  - Any state: synced SS rising -> IDLE same clk; if bit count in 1..7, frame_err pulse and
//    partial byte dropped (no write). SS rise coincident with byte_valid: the byte is processed
//    first, then IDLE.
//  - Address increment wraps within the target: char mod 2^CHAR_AW, font mod 2^FONT_AW.
//  - Latency: wr_en asserts exactly SYNC_STAGES+2 clks after the raw 8th SCK rising edge.
//  - Max one write per byte; wr_addr/wr_data/wr_font stable while wr_en high, held after.
//  - err_sticky set by cmd_err/frame_err, cleared only by reset. byte_cnt_sat saturates at 7.
//  - Reset mid-frame: frame abandoned, no wr_en; after release decoder waits in IDLE, and a
//    still-low SS opens a new frame with next full byte treated as CMD.
// STRUCTURE
//  - Shared package gpu_pkg: CMD_WR_CHAR=8'h01, CMD_WR_FONT=8'h02, state encoding localparams
//    (IDLE, CMD, ADDR_H, ADDR_L, DATA, DISCARD), CHAR_AW/FONT_AW defaults.
//  - One sub-module: spi_byte_rx (synchronisers, edge detect, shift reg, bit count,
//    byte_valid, partial flag). Frame FSM and address counter live in this module.
// TESTING
//  1. SS low, send 01 00 10 41 42, SS high -> wr_en x2: (char, 0x0010, 0x41), (char, 0x0011, 0x42);
//     no errors.
//  2. Send 02 0F FF AA BB -> font writes (0x0FFF, 0xAA) then (0x0000, 0xBB) (wrap at FONT_AW=12).
//  3. Send 7E 00 00 55 -> cmd_err one pulse, zero wr_en, err_sticky=1.
//  4. Send 01 00 00 then 5 bits, SS high -> frame_err one pulse, no wr_en; next frame
//     01 00 05 33 writes (char, 0x0005, 0x33).
//  5. rst_n low for 1 clk during DATA of 01 00 20 11 22 (after 1st byte) -> one write only,
//     outputs 0, status 0.
//  6. Latency/back-to-back: SCK = clk/8, two frames with 1 SCK period SS high between ->
//     each wr_en at SYNC_STAGES+2 clks after 8th edge, no lost bytes.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the text-mode memory controller front end:
// command bytes, frame-decoder state encoding and default RAM address widths.
package gpu_pkg;

  // Command bytes that open a write frame
  localparam logic [7:0] CMD_WR_CHAR = 8'h01;
  localparam logic [7:0] CMD_WR_FONT = 8'h02;

  // Frame decoder state encoding (also shown on the status LEDs)
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR_H  = 3'd2;
  localparam logic [2:0] S_ADDR_L  = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_CMD     = S_CMD,
    ST_ADDR_H  = S_ADDR_H,
    ST_ADDR_L  = S_ADDR_L,
    ST_DATA    = S_DATA,
    ST_DISCARD = S_DISCARD
  } dec_state_e;

  // Default address widths of the two target RAMs
  localparam int CHAR_AW_DEFAULT = 13;
  localparam int FONT_AW_DEFAULT = 12;

  // Low-order mask of aw bits within a 16-bit address
  function automatic logic [15:0] aw_mask(input int aw);
    return 16'((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver, oversampled in the clk domain.
// Synchronises SCK/MOSI/SS, detects SCK rising edges, shifts MSB first and
// pulses byte_valid_o for one clk after the 8th bit. Also reports the synced
// frame select, its rising edge and whether that edge cut a byte short.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       ss_n_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       ss_low_o,
  output logic       ss_rise_o,
  output logic       partial_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sck_prev_q;
  logic                   ss_prev_q;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             byte_q;
  logic                   byte_valid_q;

  logic sck_s, mosi_s, ss_s, sck_rise;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign ss_low_o     = ~ss_s;
  assign ss_rise_o    = ss_s & ~ss_prev_q;
  assign partial_o    = ss_rise_o & (bit_cnt_q != 3'd0);

  // Synchronise inputs, then shift one bit per SCK rise while the frame is open
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync_q   <= '0;
      mosi_sync_q  <= '0;
      ss_sync_q    <= '1;   // deselected, so a reset never fakes an SS edge
      sck_prev_q   <= 1'b0;
      ss_prev_q    <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
      sck_prev_q   <= sck_s;
      ss_prev_q    <= ss_s;
      byte_valid_q <= 1'b0;
      if (ss_s) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[6:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q       <= {shift_q[6:0], mosi_s};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_write_decoder.sv
// SPI write-frame decoder: turns host frames (cmd, addr_h, addr_l, data...)
// into single-cycle write strobes with auto-incrementing, wrapping addresses
// for the character RAM or the font RAM, plus LED status.
module spi_write_decoder
  import gpu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CHAR_AW     = CHAR_AW_DEFAULT,
  parameter int FONT_AW     = FONT_AW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        wr_en,
  output logic        wr_font,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        cmd_err,
  output logic        frame_err,
  output logic [7:0]  status
);

  localparam logic [15:0] CHAR_MASK = aw_mask(CHAR_AW);
  localparam logic [15:0] FONT_MASK = aw_mask(FONT_AW);

  logic [7:0] rx_byte;
  logic       byte_valid, ss_low, ss_rise, partial;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .sck_i        (spi_sck),
    .mosi_i       (spi_mosi),
    .ss_n_i       (spi_ss_n),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .ss_low_o     (ss_low),
    .ss_rise_o    (ss_rise),
    .partial_o    (partial)
  );

  dec_state_e  state_q;
  logic [15:0] addr_q;
  logic [15:0] addr_mask;
  logic        wr_en_q, wr_font_q, busy_q, cmd_err_q, frame_err_q, err_sticky_q;
  logic [15:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [2:0]  byte_cnt_q;

  // Address wraps inside whichever RAM the current frame targets
  assign addr_mask = wr_font_q ? FONT_MASK : CHAR_MASK;

  assign wr_en     = wr_en_q;
  assign wr_font   = wr_font_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = frame_err_q;
  assign status    = {err_sticky_q, wr_font_q, state_q, byte_cnt_q};

  // Frame FSM: advances on received bytes; a closing SS wins after the byte is handled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_font_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= partial;
      busy_q      <= ss_low;
      if (partial) err_sticky_q <= 1'b1;
      if (byte_valid && state_q != ST_IDLE && byte_cnt_q != 3'd7)
        byte_cnt_q <= byte_cnt_q + 3'd1;

      case (state_q)
        ST_IDLE: begin
          if (ss_low) begin
            state_q    <= ST_CMD;
            byte_cnt_q <= '0;
          end
        end
        ST_CMD: begin
          if (byte_valid) begin
            if (rx_byte == CMD_WR_CHAR) begin
              wr_font_q <= 1'b0;
              state_q   <= ST_ADDR_H;
            end else if (rx_byte == CMD_WR_FONT) begin
              wr_font_q <= 1'b1;
              state_q   <= ST_ADDR_H;
            end else begin
              cmd_err_q    <= 1'b1;
              err_sticky_q <= 1'b1;
              state_q      <= ST_DISCARD;
            end
          end
        end
        ST_ADDR_H: begin
          if (byte_valid) begin
            addr_q[15:8] <= rx_byte;
            state_q      <= ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (byte_valid) begin
            addr_q  <= {addr_q[15:8], rx_byte} & addr_mask;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= rx_byte;
            addr_q    <= (addr_q + 16'd1) & addr_mask;
          end
        end
        ST_DISCARD: state_q <= ST_DISCARD;
        default:    state_q <= ST_IDLE;
      endcase

      if (ss_rise) state_q <= ST_IDLE;
    end
  end

endmodule
